axi_wr_frame_gen: RTL and testbench

Upstream feeder for `array_wr_ctrl`. It accepts one AXI-style incrementing write burst at a time on the AW/W channels and emits one 87-bit write frame per beat on the `axi_frame_wr_*` valid/ready interface. Bursts are split into row-bounded frame groups (sof … eof) so that each group stays within one array row. After each eof it waits for `wr_done` from `array_wr_ctrl`, and it returns a single B response per burst.

---
 rtl/axi_wr_frame_gen.sv | 103 ++++++++++
 tb/tb_axi_wr_frame_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/axi_wr_frame_gen.sv
// AXI-style incrementing write burst to array write-frame converter.
// Splits each burst into row-bounded sof..eof groups and waits for wr_done after each group.
module axi_wr_frame_gen #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
  parameter int AXI_RADDR_WIDTH = 14,
  parameter int AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  awaddr,
  input  logic [7:0]                 awlen,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXI_DATA_WIDTH-1:0]  wdata,
  input  logic                       wlast,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [AXI_FRAME_WIDTH-1:0] axi_frame_wr_data,
  output logic                       axi_frame_wr_valid,
  input  logic                       axi_frame_wr_ready,
  input  logic                       wr_done
);

  typedef enum logic [1:0] {IDLE, DATA, WAIT_DONE, RESP} state_t;

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [8:0]                  rem_q;
  logic                        first_q, err_q, awready_q, fvalid_q;
  logic [AXI_FRAME_WIDTH-1:0]  frame_q;

  logic aw_fire, w_fire, last_beat, beat_eof;

  assign aw_fire   = awready_q && awvalid && (state_q == IDLE);
  assign w_fire    = wready && wvalid;
  assign last_beat = (rem_q == 9'd1);
  // Column all-ones closes the row group even when beats remain.
  assign beat_eof  = last_beat || (&addr_q[AXI_CADDR_WIDTH-1:0]);

  assign awready            = awready_q;
  assign axi_frame_wr_valid = fvalid_q;
  assign axi_frame_wr_data  = frame_q;

  always_comb begin
    state_d = state_q;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    case (state_q)
      IDLE:      if (aw_fire) state_d = DATA;
      DATA: begin
        wready = !fvalid_q || axi_frame_wr_ready;
        if (w_fire && beat_eof) state_d = WAIT_DONE;
      end
      WAIT_DONE: if (wr_done) state_d = (rem_q == 9'd0) ? RESP : DATA;
      RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (bready) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      fvalid_q  <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == IDLE);
      if (aw_fire) begin
        addr_q  <= awaddr;
        rem_q   <= {1'b0, awlen} + 9'd1;
        first_q <= 1'b1;
        err_q   <= 1'b0;
      end
      if (w_fire) begin
        frame_q  <= {first_q, beat_eof, 1'b1, addr_q, wdata};
        fvalid_q <= 1'b1;
        addr_q   <= addr_q + 1'b1;
        rem_q    <= rem_q - 9'd1;
        first_q  <= beat_eof;
        // Beat count is authoritative; wlast only flags a mismatch.
        if (wlast != last_beat) err_q <= 1'b1;
      end else if (fvalid_q && axi_frame_wr_ready) begin
        fvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_frame_gen.sv
// Directed table-driven bench for axi_wr_frame_gen plus reset sequences.
module tb_axi_wr_frame_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [86:0] fdata;
  logic        fvalid, fready;
  logic        wr_done;

  int tot = 0;
  int bad = 0;

  axi_wr_frame_gen dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .axi_frame_wr_data(fdata), .axi_frame_wr_valid(fvalid),
    .axi_frame_wr_ready(fready), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  len;
    logic [63:0] data0;
    int          wlast_beat;  // -1: never asserted
    logic [7:0]  sof_m;       // expected sof per beat
    logic [7:0]  eof_m;       // expected eof per beat
    logic [1:0]  bresp;
    bit          bp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_aw(input logic [19:0] a, input logic [7:0] l, output bit hs);
    awaddr = a; awlen = l; awvalid = 1'b1; hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      #1;
      if (awready) hs = 1'b1;
      @(negedge clk);
    end
    awvalid = 1'b0;
    if (!hs) check("aw_handshake_timeout", 0, 1);
  endtask

  task automatic run_burst(input vec_t v);
    int sent, got, done_cnt, gap;
    bit pending, bv_seen, prev_stall, hs, fin;
    logic [86:0] prev_frame, exp;
    // wr_done while idle must be ignored
    @(negedge clk); wr_done = 1'b1;
    @(negedge clk); wr_done = 1'b0;
    do_aw(v.addr, v.len, hs);
    sent = 0; got = 0; done_cnt = 0; gap = 0;
    pending = 0; bv_seen = 0; prev_stall = 0; fin = 0; prev_frame = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      wr_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin wr_done = 1'b1; pending = 0; end
      end
      fready = v.bp ? (cyc % 2 == 0) : 1'b1;
      if (sent <= int'(v.len) && (!v.bp || gap == 0)) begin
        wvalid = 1'b1; wdata = v.data0 + 64'(sent); wlast = (sent == v.wlast_beat);
      end else begin
        wvalid = 1'b0; wlast = 1'b0;
      end
      if (gap > 0) gap--;
      bready = bv_seen;
      #1;
      if (prev_stall) check("frame_hold", {fvalid, fdata}, {1'b1, prev_frame});
      if (pending) check("frame_before_wr_done", fvalid, 0);
      prev_stall = fvalid && !fready;
      prev_frame = fdata;
      if (fvalid && fready) begin
        if (got <= int'(v.len)) begin
          exp = {v.sof_m[got], v.eof_m[got], 1'b1, v.addr + 20'(got), v.data0 + 64'(got)};
          check("frame", fdata, exp);
          if (v.eof_m[got]) begin pending = 1; done_cnt = 5; end
        end else begin
          check("extra_frame", got, v.len);
        end
        got++;
      end
      if (wready && wvalid) begin sent++; gap = v.bp ? 4 : 0; end
      if (bvalid) begin
        if (!bv_seen) begin check("bresp", bresp, v.bresp); bv_seen = 1; end
        else if (bready) fin = 1;
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; wr_done = 1'b0;
    if (!fin) check("burst_timeout", 0, 1);
    #1;
    check("resp_exit_awready_bvalid", {awready, bvalid}, 2'b10);
    check("frame_count", got, int'(v.len) + 1);
  endtask

  initial begin
    bit hs;
    //            addr      len    data0   wlast sof_m    eof_m    bresp  bp
    tbl[0] = '{20'd100,   8'd0 + 8'd3, 64'd100, 3,  8'b0001,  8'b1000,  2'b00, 0};
    tbl[1] = '{20'd100,   8'd0,        64'd100, 0,  8'b0001,  8'b0001,  2'b00, 0};
    tbl[2] = '{20'd62,    8'd3,        64'd500, 3,  8'b0101,  8'b1010,  2'b00, 0};
    tbl[3] = '{20'd200,   8'd5,        64'd900, 5,  8'b000001,8'b100000,2'b00, 1};
    tbl[4] = '{20'd100,   8'd3,        64'd40,  1,  8'b0001,  8'b1000,  2'b10, 0};
    tbl[5] = '{20'd100,   8'd3,        64'd60, -1,  8'b0001,  8'b1000,  2'b10, 0};
    tbl[6] = '{20'hFFFFF, 8'd1,        64'd77,  1,  8'b11,    8'b11,    2'b00, 0};

    rst = 1'b1; awaddr = '0; awlen = '0; awvalid = 0; wdata = '0; wlast = 0;
    wvalid = 0; bready = 0; fready = 0; wr_done = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {awready, wready, bvalid, bresp, fvalid, fdata}, '0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("awready_after_reset", awready, 1);

    for (int i = 0; i < 7; i++) run_burst(tbl[i]);

    // reset in the middle of a burst with a frame held
    @(negedge clk);
    do_aw(20'd300, 8'd3, hs);
    wvalid = 1'b1; wdata = 64'd7; wlast = 1'b0; fready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_frame_valid", fvalid, 1);
    rst = 1'b1;
    #1;
    check("reset_mid_burst", {awready, wready, bvalid, bresp, fvalid, fdata}, '0);
    wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0; fready = 1'b1;
    run_burst(tbl[0]);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
